// File: rtl/video_pkg.sv
// Shared video types: default screen geometry, packer FSM states and the
// FIFO entry layout used between the pixel tagger and the stream output.
package video_pkg;

    localparam int SCREEN_WIDTH_DEF  = 640;
    localparam int SCREEN_HEIGHT_DEF = 480;
    localparam int RBG_SIZE_DEF      = 24;

    // SEEK waits for a start-of-frame pixel; STREAM buffers every pixel.
    typedef enum logic {
        SEEK   = 1'b0,
        STREAM = 1'b1
    } packer_state_t;

    // One buffered pixel: frame-boundary flags travel with the colour.
    typedef struct packed {
        logic                    sop;
        logic                    eop;
        logic [RBG_SIZE_DEF-1:0] colour;
    } pixel_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead register-array FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable. A write is accepted while full when a
// read happens in the same cycle (the slot being freed is the one written).
module pixel_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_fire;
    logic             rd_fire;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Advance each pointer by one on its accepted operation.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_fire};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_fire};
    end

    // Pointer registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// Tags incoming coordinate pixels with frame start/end flags, buffers them and
// presents them as a ready/valid stream. After start-up or an overflow the
// input side discards pixels until the next frame start.
//
// Output handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready low the beat
// (out_data/out_sop/out_eop) is held unchanged. in_ready is advisory only.
module pixel_stream_packer
    import video_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int RBG_SIZE      = RBG_SIZE_DEF,
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    input  logic [RBG_SIZE-1:0]   in_colour,
    output logic                  in_ready,
    output logic [RBG_SIZE-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  overflow,
    output logic [15:0]           frame_count,
    output packer_state_t         state_dbg
);

    packer_state_t state_q, state_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   frame_count_q, frame_count_d;

    pixel_entry_t  wr_entry;
    pixel_entry_t  head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          rd_fire;
    logic          space;
    logic          wr_req;
    logic          sop_tag;
    logic          eop_tag;

    // Rows count down, so a frame begins at the top row value and ends at row 1.
    assign sop_tag  = (in_x == '0) && (in_y == DATA_WIDTH'(SCREEN_HEIGHT));
    assign eop_tag  = (in_x == DATA_WIDTH'(SCREEN_WIDTH - 1)) && (in_y == DATA_WIDTH'(1));
    assign wr_entry = '{sop: sop_tag, eop: eop_tag, colour: in_colour};

    assign rd_fire  = !fifo_empty && out_ready;
    assign space    = !fifo_full || rd_fire;

    pixel_fifo #(
        .WIDTH ($bits(pixel_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_req),
        .wr_data (wr_entry),
        .rd_en   (out_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Outputs are masked while empty so the idle stream reads as all zero.
    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_empty ? '0 : head.colour;
    assign out_sop     = !fifo_empty && head.sop;
    assign out_eop     = !fifo_empty && head.eop;
    assign in_ready    = !fifo_full;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;
    assign state_dbg   = state_q;

    // Input FSM: decide whether this pixel is written, dropped or ignored.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        wr_req     = 1'b0;
        if (in_valid) begin
            case (state_q)
                SEEK: begin
                    if (sop_tag && space) begin
                        wr_req  = 1'b1;
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (space) begin
                        wr_req = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = SEEK;
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    // Count frames as their final beat leaves the stream.
    always_comb begin
        frame_count_d = frame_count_q;
        if (rd_fire && head.eop) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // State, sticky overflow and frame counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SEEK;
            overflow_q    <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule
